spike_array: RTL and testbench
==============================

SPIKE_ARRAY -- requirements
Module: spike_array

Interface
REQ-001 SHALL have parameter W, default 8, pixel sample width (1..8), using data_in[W-1:0].
REQ-002 SHALL have parameter N, default 4, channel count (1..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, spike event FIFO depth (2, 4 or 8).
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port address, input, 4, register address.
REQ-007 SHALL have port data_write, input, 1, write strobe.
REQ-008 SHALL have port data_read, input, 1, read strobe (pops FIFO at EVENT).
REQ-009 SHALL have port data_in, input, 8, write data.
REQ-010 SHALL have port data_out, output, 8, combinational read data.
REQ-011 SHALL have port uo_out, output, 8, [3:0] per-channel spike pulse, [4] FIFO non-empty, [7:5] count[2:0].

Function
REQ-012 SHALL decode: 0x0-0x3 PIXEL[ch] (RW), 0x4 THRESHOLD (RW), 0x5 CTRL (RW), 0x6 STATUS (R/W1C), 0x7 COUNT (R, any write clears), 0x8 EVENT (R, pop on data_read).
REQ-013 SHALL leave unmapped or ch>=N addresses write-ignored, reading 0x00.
REQ-014 SHALL define CTRL as: [0] mode (0 delta, 1 LIF), [3:1] leak shift k, [7:4] refractory samples R.
REQ-015 SHALL, on a PIXEL write at edge E0, capture sample and a pending flag, then evaluate that channel only at E1; one evaluation per cycle, no channel evaluated without a write.
REQ-016 SHALL in delta mode spike when |sample - prev| >= THRESHOLD, then set prev to sample; prev is 0 after reset.
REQ-017 SHALL in LIF mode compute m' = m - (k ? m>>k : 0) + sample over W+4 bits, saturating at all-ones; spike when m' >= THRESHOLD, then set m to 0, else set m to m'.
REQ-018 SHALL give each channel a refractory counter: spike loads R; while nonzero, an evaluation decrements it and suppresses the spike (delta still updates prev; LIF holds m at 0).
REQ-019 SHALL on spike at E1 drive uo_out[ch] high for exactly one cycle (E1-E2), set STATUS[ch] sticky, increment COUNT, and push ch into the FIFO.
REQ-020 SHALL wrap COUNT 8-bit (255->0); COUNT clear SHALL win over a same-cycle increment.
REQ-021 SHALL define STATUS as: [3:0] sticky spike flags, [6] sticky overflow, [7] FIFO non-empty; writing 1 to [6] or [3:0] clears them; set SHALL win over a same-cycle clear.
REQ-022 SHALL read EVENT as {non-empty, 5'b0, head ch[1:0]}, or 0x00 when empty; data_read at 0x8 pops if non-empty, else no effect.
REQ-023 SHALL on push when full without pop drop the new event and set overflow; push+pop same cycle when full SHALL succeed without overflow.
REQ-024 SHALL read PIXEL[ch] as the last written sample zero-extended.

Reset
REQ-025 SHALL on rst_n low clear samples, prev, membranes, refractory counters, pending flags, FIFO, COUNT, STATUS, CTRL and uo_out to 0, and set THRESHOLD to 20 (0x14).
REQ-026 SHALL discard a pending evaluation interrupted by reset; no spike after release.

Structure
REQ-027 SHALL place address constants, CTRL field positions, mode encoding and default threshold in shared package spike_pkg.
REQ-028 SHALL implement the event FIFO as sub-module spike_event_fifo (parametric depth, push/pop/full/empty).

Verification
REQ-029 SHALL cover delta: ch0 writes 10 then 35, threshold 20 -> single uo_out[0] pulse after second write, COUNT=1, EVENT=0x80, after pop EVENT=0x00.
REQ-030 SHALL cover LIF: CTRL=0x07, ch2 writes 8,8,8 -> m 8, 15, then 22 fires on third write, m=0, STATUS=0x84.
REQ-031 SHALL cover refractory: CTRL=0x20, ch1 writes 0,100,0,100,0 -> spikes on 2nd and 5th only, COUNT=2.
REQ-032 SHALL cover overflow: 5 spiking writes without pops, FIFO_DEPTH=4 -> STATUS[6]=1, four events read in order, writing 0x40 to STATUS clears it.
REQ-033 SHALL cover reset mid-operation and COUNT wrap: rst_n low the cycle after a spiking write -> no pulse, THRESHOLD=0x14; 256 spikes -> COUNT=0x00.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared constants for the spike array: register map, CTRL field layout,
// evaluation mode encoding and the threshold loaded at reset.
package spike_pkg;

  localparam logic [3:0] ADDR_PIXEL0    = 4'h0;
  localparam logic [3:0] ADDR_THRESHOLD = 4'h4;
  localparam logic [3:0] ADDR_CTRL      = 4'h5;
  localparam logic [3:0] ADDR_STATUS    = 4'h6;
  localparam logic [3:0] ADDR_COUNT     = 4'h7;
  localparam logic [3:0] ADDR_EVENT     = 4'h8;

  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_K_LSB    = 1;
  localparam int CTRL_R_LSB    = 4;

  localparam int STATUS_OVF_BIT = 6;

  localparam logic [7:0] DEFAULT_THRESHOLD = 8'h14;

  typedef enum logic {
    MODE_DELTA = 1'b0,
    MODE_LIF   = 1'b1
  } mode_e;

endpackage

// File: rtl/spike_event_fifo.sv
// Small circular FIFO holding the channel numbers of spike events.
// DEPTH is a power of two so the read/write pointers wrap on their own.
module spike_event_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] slot_q [DEPTH];
  logic [DW-1:0] slot_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside a pop.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    slot_d  = slot_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (do_push) begin
      slot_d[wr_q] = push_data;
      wr_d         = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  assign head = slot_q[rd_q];

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spike_array.sv
// Register-mapped array of N spiking channels. A PIXEL write captures a
// sample and marks the channel pending; on the following edge that channel
// is evaluated in delta or leaky-integrate-and-fire mode and, on a spike,
// pulses uo_out, sets its sticky flag, bumps COUNT and queues its number.
module spike_array
  import spike_pkg::*;
#(
  parameter int W          = 8,
  parameter int N          = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic       data_read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] uo_out
);

  localparam int MW = W + 4;

  logic [W-1:0]  sample_q [N];
  logic [W-1:0]  sample_d [N];
  logic [W-1:0]  prev_q   [N];
  logic [W-1:0]  prev_d   [N];
  logic [MW-1:0] mem_q    [N];
  logic [MW-1:0] mem_d    [N];
  logic [3:0]    refr_q   [N];
  logic [3:0]    refr_d   [N];
  logic [N-1:0]  pend_q, pend_d;
  logic [7:0]    thresh_q, thresh_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    count_q, count_d;
  logic [3:0]    flags_q, flags_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    pulse_q, pulse_d;

  mode_e         ev_mode;
  logic [2:0]    k_shift;
  logic [3:0]    r_load;
  logic [W-1:0]  diff;
  logic [MW-1:0] leak;
  logic [MW:0]   msum;
  logic [MW-1:0] mnext;
  logic          hit;
  logic [N-1:0]  spike_vec;
  logic [3:0]    spike4;
  logic          push;
  logic [1:0]    push_ch;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [1:0]    fifo_head;

  // Evaluate the pending channel (writes arrive one per cycle, so at most one flag is set) and capture new writes.
  always_comb begin
    ev_mode   = mode_e'(ctrl_q[CTRL_MODE_BIT]);
    k_shift   = ctrl_q[CTRL_K_LSB +: 3];
    r_load    = ctrl_q[CTRL_R_LSB +: 4];
    sample_d  = sample_q;
    prev_d    = prev_q;
    mem_d     = mem_q;
    refr_d    = refr_q;
    pend_d    = '0;
    spike_vec = '0;
    push_ch   = '0;
    diff      = '0;
    leak      = '0;
    msum      = '0;
    mnext     = '0;
    hit       = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (pend_q[c]) begin
        diff  = (sample_q[c] >= prev_q[c]) ? (sample_q[c] - prev_q[c]) : (prev_q[c] - sample_q[c]);
        leak  = (k_shift != 3'd0) ? (mem_q[c] >> k_shift) : '0;
        msum  = (MW+1)'(mem_q[c] - leak) + (MW+1)'(sample_q[c]);
        mnext = msum[MW] ? '1 : msum[MW-1:0];
        if (ev_mode == MODE_LIF) begin
          hit = (16'(mnext) >= 16'(thresh_q));
        end else begin
          hit = (16'(diff) >= 16'(thresh_q));
        end
        if (ev_mode == MODE_DELTA) begin
          prev_d[c] = sample_q[c];
        end
        if (refr_q[c] != 4'd0) begin
          refr_d[c] = refr_q[c] - 4'd1;
          if (ev_mode == MODE_LIF) begin
            mem_d[c] = '0;
          end
        end else if (hit) begin
          spike_vec[c] = 1'b1;
          push_ch      = 2'(c);
          refr_d[c]    = r_load;
          if (ev_mode == MODE_LIF) begin
            mem_d[c] = '0;
          end
        end else if (ev_mode == MODE_LIF) begin
          mem_d[c] = mnext;
        end
      end
      if (data_write && (address == ADDR_PIXEL0 + 4'(c))) begin
        sample_d[c] = data_in[W-1:0];
        pend_d[c]   = 1'b1;
      end
    end
  end

  // Control/status registers: clears from writes are applied first so same-cycle sets win.
  always_comb begin
    spike4         = '0;
    spike4[N-1:0]  = spike_vec;
    push           = |spike_vec;
    fifo_pop       = data_read && (address == ADDR_EVENT) && !fifo_empty;
    pulse_d        = spike4;
    thresh_d       = thresh_q;
    ctrl_d         = ctrl_q;
    flags_d        = flags_q;
    ovf_d          = ovf_q;
    count_d        = count_q + 8'(push);
    if (data_write && (address == ADDR_THRESHOLD)) begin
      thresh_d = data_in;
    end
    if (data_write && (address == ADDR_CTRL)) begin
      ctrl_d = data_in;
    end
    if (data_write && (address == ADDR_STATUS)) begin
      flags_d = flags_q & ~data_in[3:0];
      if (data_in[STATUS_OVF_BIT]) begin
        ovf_d = 1'b0;
      end
    end
    if (data_write && (address == ADDR_COUNT)) begin
      count_d = '0;
    end
    flags_d = flags_d | spike4;
    if (push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Combinational read-back; unmapped addresses and absent channels read zero.
  always_comb begin
    data_out = '0;
    for (int c = 0; c < N; c++) begin
      if (address == ADDR_PIXEL0 + 4'(c)) begin
        data_out = 8'(sample_q[c]);
      end
    end
    case (address)
      ADDR_THRESHOLD: data_out = thresh_q;
      ADDR_CTRL:      data_out = ctrl_q;
      ADDR_STATUS:    data_out = {!fifo_empty, ovf_q, 2'b00, flags_q};
      ADDR_COUNT:     data_out = count_q;
      ADDR_EVENT:     data_out = fifo_empty ? 8'h00 : {1'b1, 5'b00000, fifo_head};
      default:        ;
    endcase
  end

  assign uo_out = {count_q[2:0], !fifo_empty, pulse_q};

  // All channel and register state; reset also drops any evaluation still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        sample_q[c] <= '0;
        prev_q[c]   <= '0;
        mem_q[c]    <= '0;
        refr_q[c]   <= '0;
      end
      pend_q   <= '0;
      thresh_q <= DEFAULT_THRESHOLD;
      ctrl_q   <= '0;
      count_q  <= '0;
      flags_q  <= '0;
      ovf_q    <= 1'b0;
      pulse_q  <= '0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
      mem_q    <= mem_d;
      refr_q   <= refr_d;
      pend_q   <= pend_d;
      thresh_q <= thresh_d;
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
    end
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_ch),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spike_array.sv
// Scoreboard bench for spike_array: every bus cycle goes through
// applyStimulus, which consults a behavioural model and queues expected
// read data and spike pulses; an independent monitor compares them.
module tb_spike_array;

  localparam int W          = 8;
  localparam int N          = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MMAX       = (1 << (W + 4)) - 1;
  localparam int SMASK      = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] address = '0;
  logic       data_write = 1'b0;
  logic       data_read = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic [7:0] uo_out;

  spike_array #(.W(W), .N(N), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .data_write (data_write),
    .data_read  (data_read),
    .data_in    (data_in),
    .data_out   (data_out),
    .uo_out     (uo_out)
  );

  typedef struct {
    int cyc;
    int mask;
    int cnt;
    int ne;
  } pulse_t;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     rd_q[$];
  pulse_t pq[$];

  int m_sample[N];
  int m_prev[N];
  int m_mem[N];
  int m_refr[N];
  int m_thr, m_ctrl, m_count, m_flags, m_ovf;
  int m_fifo[$];
  bit pend_v;
  int pend_ch, pend_smp;

  // Free-running clock and cycle counter used to time-stamp expected pulses.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < N; c++) begin
      m_sample[c] = 0;
      m_prev[c]   = 0;
      m_mem[c]    = 0;
      m_refr[c]   = 0;
    end
    m_thr   = 20;
    m_ctrl  = 0;
    m_count = 0;
    m_flags = 0;
    m_ovf   = 0;
    m_fifo.delete();
    pend_v  = 1'b0;
  endfunction

  function automatic int modelRead(input int a);
    if (a < N) return m_sample[a];
    case (a)
      4: return m_thr;
      5: return m_ctrl;
      6: return ((m_fifo.size() > 0) ? 128 : 0) | (m_ovf ? 64 : 0) | m_flags;
      7: return m_count;
      8: return (m_fifo.size() > 0) ? (128 | m_fifo[0]) : 0;
      default: return 0;
    endcase
  endfunction

  // Apply one clock edge worth of behaviour: evaluate last cycle's write, then this cycle's bus operation.
  function automatic void modelEdge(input bit wr, input bit rd, input int a, input int d);
    bit     spiked = 1'b0;
    int     sch = 0;
    int     mode, k, r, diff, mn, hit;
    pulse_t e;
    bit     popped;
    if (pend_v) begin
      mode = m_ctrl & 1;
      k    = (m_ctrl >> 1) & 7;
      r    = (m_ctrl >> 4) & 15;
      sch  = pend_ch;
      diff = pend_smp - m_prev[sch];
      if (diff < 0) diff = -diff;
      mn = m_mem[sch] - ((k != 0) ? (m_mem[sch] >> k) : 0) + pend_smp;
      if (mn > MMAX) mn = MMAX;
      hit = (mode == 1) ? (mn >= m_thr) : (diff >= m_thr);
      if (mode == 0) m_prev[sch] = pend_smp;
      if (m_refr[sch] > 0) begin
        m_refr[sch]--;
        if (mode == 1) m_mem[sch] = 0;
      end else if (hit != 0) begin
        spiked      = 1'b1;
        m_refr[sch] = r;
        if (mode == 1) m_mem[sch] = 0;
      end else if (mode == 1) begin
        m_mem[sch] = mn;
      end
    end
    pend_v = 1'b0;
    popped = rd && (a == 8) && (m_fifo.size() > 0);
    if (wr) begin
      if (a < N) begin
        m_sample[a] = d & SMASK;
        pend_v      = 1'b1;
        pend_ch     = a;
        pend_smp    = d & SMASK;
      end else if (a == 4) m_thr = d;
      else if (a == 5) m_ctrl = d;
      else if (a == 6) begin
        m_flags = m_flags & ~(d & 15);
        if ((d & 64) != 0) m_ovf = 0;
      end
    end
    if (spiked) begin
      m_flags = m_flags | (1 << sch);
      m_count = (m_count + 1) % 256;
    end
    if (wr && (a == 7)) m_count = 0;
    if (popped) void'(m_fifo.pop_front());
    if (spiked) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(sch);
      else m_ovf = 1;
      e.cyc  = cyc;
      e.mask = 1 << sch;
      e.cnt  = m_count & 7;
      e.ne   = (m_fifo.size() > 0) ? 1 : 0;
      pq.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input int a, input bit wr, input bit rd, input int d);
    address    = 4'(a);
    data_write = wr;
    data_read  = rd;
    data_in    = 8'(d);
    if (rd) rd_q.push_back(modelRead(a));
    @(posedge clk);
    #1;
    modelEdge(wr, rd, a, d);
    data_write = 1'b0;
    data_read  = 1'b0;
  endtask

  task automatic writeReg(input int a, input int d);
    applyStimulus(a, 1'b1, 1'b0, d);
  endtask

  task automatic readReg(input int a);
    applyStimulus(a, 1'b0, 1'b1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 1'b0, 0);
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    data_write = 1'b0;
    data_read  = 1'b0;
    modelReset();
    pq.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares reads while data_read is up and every spike pulse against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_read) begin
        if (rd_q.size() == 0) checkOutput("read_unexpected", data_out, 0);
        else checkOutput($sformatf("read_addr%0d", address), data_out, rd_q.pop_front());
      end
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        checkOutput("pulse_missing", 0, pq[0].mask);
        void'(pq.pop_front());
      end
      if (uo_out[3:0] != 4'd0) begin
        if (pq.size() == 0) checkOutput("pulse_unexpected", uo_out[3:0], 0);
        else begin
          checkOutput("pulse_cycle", cyc, pq[0].cyc);
          checkOutput("pulse_mask", uo_out[3:0], pq[0].mask);
          checkOutput("pulse_count_bits", uo_out[7:5], pq[0].cnt);
          checkOutput("pulse_nonempty", uo_out[4], pq[0].ne);
          void'(pq.pop_front());
        end
      end
    end
  end

  initial begin
    modelReset();
    doReset();

    // Reset values of every register.
    for (int a = 0; a < 16; a++) readReg(a);

    // Delta detection: 10 then 35 on channel 0, then pop the single event.
    writeReg(0, 10);
    writeReg(0, 35);
    idle(1);
    readReg(7);
    readReg(8);
    readReg(8);

    // LIF with leak shift 3 on channel 2.
    doReset();
    writeReg(5, 8'h07);
    writeReg(2, 8);
    writeReg(2, 8);
    writeReg(2, 8);
    idle(1);
    readReg(6);
    writeReg(2, 8);
    idle(1);
    readReg(6);

    // Refractory period of two samples on channel 1.
    doReset();
    writeReg(5, 8'h20);
    writeReg(1, 0);
    writeReg(1, 100);
    writeReg(1, 0);
    writeReg(1, 100);
    writeReg(1, 0);
    idle(1);
    readReg(7);

    // Overflow with five events into a four-deep FIFO, then overflow clear.
    doReset();
    writeReg(0, 100);
    writeReg(1, 100);
    writeReg(2, 100);
    writeReg(3, 100);
    writeReg(0, 0);
    idle(1);
    readReg(6);
    for (int i = 0; i < 5; i++) readReg(8);
    writeReg(6, 8'h40);
    readReg(6);

    // Push and pop on the same edge while full, COUNT clear and STATUS clear racing a spike.
    doReset();
    for (int c = 0; c < 4; c++) writeReg(c, 100);
    writeReg(0, 0);
    readReg(8);
    readReg(6);
    for (int i = 0; i < 4; i++) readReg(8);
    writeReg(1, 0);
    writeReg(7, 8'h55);
    readReg(7);
    writeReg(6, 8'h0F);
    writeReg(3, 0);
    writeReg(6, 8'h08);
    readReg(6);
    writeReg(9, 8'hFF);
    readReg(9);

    // Reset the cycle after a spiking write: no pulse, threshold back to default.
    doReset();
    writeReg(0, 200);
    doReset();
    idle(2);
    readReg(4);
    readReg(7);

    // COUNT wraps after 256 spikes.
    for (int i = 0; i < 256; i++) writeReg(0, (i % 2 == 0) ? 255 : 0);
    idle(1);
    readReg(7);

    // Randomised traffic against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 45) writeReg($urandom_range(0, 3), $urandom_range(0, 255));
      else if (sel < 52) writeReg(4, $urandom_range(0, 120));
      else if (sel < 56) writeReg(5, $urandom_range(0, 255));
      else if (sel < 76) readReg($urandom_range(0, 15));
      else if (sel < 88) readReg(8);
      else if (sel < 93) writeReg(6, $urandom_range(0, 255));
      else if (sel < 95) writeReg(7, $urandom_range(0, 255));
      else if (sel < 97) writeReg($urandom_range(9, 15), $urandom_range(0, 255));
      else idle(1);
    end
    idle(3);
    for (int a = 0; a < 9; a++) readReg(a);
    idle(2);

    checkOutput("pulse_queue_drain", pq.size(), 0);
    checkOutput("read_queue_drain", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
